bin_to_bcd_seq: RTL and testbench

- Sequential shift-add-3 (double-dabble) converter: takes a binary value and produces packed BCD digits.
- Sits directly upstream of the per-digit 7-segment decoders; each 4-bit slice of bcd_out drives one decoder input.
- Converts counters and status values (e.g. frame/error counts) into decimal display digits.
- One conversion per start pulse; result held stable between conversions so displays do not flicker.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_add3.sv | 17 +
 rtl/bin_to_bcd_seq.sv | 127 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [0:0] {IDLE, CONV} bcd_state_e;

    localparam int unsigned BCD_W       = 4;
    localparam int unsigned ADD3_THRESH = 5;

    // Decimal digits needed for 2^bin_w-1: floor(bin_w*log10(2))+1 (2^n is never a power of 10).
    function automatic int unsigned bcd_req_digits(input int unsigned bin_w);
        longint unsigned prod;
        prod = longint'(bin_w) * 64'd30103;
        return int'(prod / 64'd100000) + 1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Combinational double-dabble digit adjust: adds 3 to a BCD digit of 5 or more.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    output logic [BCD_W-1:0] digit_o
);

    always_comb begin
        if (digit_i >= BCD_W'(ADD3_THRESH)) begin
            digit_o = digit_i + BCD_W'(3);
        end else begin
            digit_o = digit_i;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one result per start pulse.
// Optional leading-zero blank mask enabled by BCD_LEADING_ZERO_BLANK_EN.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]       blank
);

    localparam int unsigned BCD_F = BCD_W * DIGITS;
    localparam int unsigned SR_W  = BIN_W + BCD_F;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    if (DIGITS < bcd_req_digits(BIN_W)) begin : g_digits_check
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    bcd_state_e       state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_F-1:0] bcd_q, bcd_d;
    logic             done_q, done_d;

    logic [BCD_F-1:0] bcd_adj;
    logic [SR_W-1:0]  sr_adj;
    logic [SR_W-1:0]  sr_shift;
    logic [BCD_F-1:0] bcd_next;
    logic             last;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (sr_q[BIN_W + g*BCD_W +: BCD_W]),
            .digit_o (bcd_adj[g*BCD_W +: BCD_W])
        );
    end

    assign sr_adj   = {bcd_adj, sr_q[BIN_W-1:0]};
    assign sr_shift = {sr_adj[SR_W-2:0], 1'b0};
    assign bcd_next = sr_shift[SR_W-1:BIN_W];
    assign last     = (cnt_q == CNT_W'(BIN_W - 1));

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = {{BCD_F{1'b0}}, bin_in};
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                sr_d  = sr_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    bcd_d   = bcd_next;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q == CONV);
    assign done    = done_q;
    assign bcd_out = bcd_q;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_calc;
    logic [DIGITS-1:0] blank_q;
    logic              nz_above;

    // Scan from the most significant digit down; the ones digit is never blanked.
    always_comb begin
        blank_calc = '0;
        nz_above   = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            nz_above      = nz_above | (bcd_next[i*BCD_W +: BCD_W] != '0);
            blank_calc[i] = ~nz_above;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= '0;
        end else if (state_q == CONV && last) begin
            blank_q <= blank_calc;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed, table-driven bench for bin_to_bcd_seq plus multi-cycle corner sequences.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [19:0] bcd_out;
    logic [4:0]  blank;

    int tests;
    int fails;
    int cyc;
    int e0;

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic [4:0]  blank_en;
    } vec_t;

    vec_t vecs[11];

    bin_to_bcd_seq #(
        .BIN_W  (16),
        .DIGITS (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .blank   (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] exp_blank(input logic [4:0] en_val);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        return en_val;
`else
        return (en_val & 5'b0);
`endif
    endfunction

    // Called at a negedge; leaves at the negedge after the accepting edge E0.
    task automatic kick(input logic [15:0] v);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        bin_in = ~v;
        e0     = cyc;
    endtask

    task automatic wait_done(output int lat, output bit ok);
        ok  = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ok  = 1'b1;
                lat = cyc - e0;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_one(input string name, input logic [15:0] v, input logic [19:0] exp,
                           input logic [4:0] exp_bl, input bit check_timing);
        int lat;
        bit ok;
        kick(v);
        if (check_timing) check({name, " busy"}, 32'(busy), 32'd1);
        wait_done(lat, ok);
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: got no done, expected done", name);
        end else begin
            check({name, " bcd"}, 32'(bcd_out), 32'(exp));
            check({name, " busy@done"}, 32'(busy), 32'd0);
            if (check_timing) begin
                check({name, " blank"}, 32'(blank), 32'(exp_bl));
                check({name, " latency"}, 32'(lat), 32'd16);
            end
        end
    endtask

    initial begin
        int lat;
        bit ok;
        bit seen;
        tests  = 0;
        fails  = 0;
        e0     = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;

        vecs[0]  = '{16'd0,     20'h00000, 5'b11110};
        vecs[1]  = '{16'd65535, 20'h65535, 5'b00000};
        vecs[2]  = '{16'd1234,  20'h01234, 5'b10000};
        vecs[3]  = '{16'd42,    20'h00042, 5'b11100};
        vecs[4]  = '{16'd10005, 20'h10005, 5'b00000};
        vecs[5]  = '{16'd9999,  20'h09999, 5'b10000};
        vecs[6]  = '{16'd7,     20'h00007, 5'b11110};
        vecs[7]  = '{16'd100,   20'h00100, 5'b11000};
        vecs[8]  = '{16'd59999, 20'h59999, 5'b00000};
        vecs[9]  = '{16'd32768, 20'h32768, 5'b00000};
        vecs[10] = '{16'd1000,  20'h01000, 5'b10000};

        repeat (3) @(negedge clk);
        check("reset bcd", 32'(bcd_out), 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset blank", 32'(blank), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[k]) begin
            run_one($sformatf("vec%0d", k), vecs[k].bin, vecs[k].bcd,
                    exp_blank(vecs[k].blank_en), 1'b1);
            @(negedge clk);
            check($sformatf("vec%0d done width", k), 32'(done), 32'd0);
            check($sformatf("vec%0d hold", k), 32'(bcd_out), 32'(vecs[k].bcd));
        end

        // Start while busy is ignored; a start on the done cycle is accepted.
        kick(16'd1234);
        repeat (4) @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd9999;
        @(negedge clk);
        start  = 1'b0;
        wait_done(lat, ok);
        check("ignored start done", 32'(ok), 32'd1);
        check("ignored start bcd", 32'(bcd_out), 32'h01234);
        check("ignored start latency", 32'(lat), 32'd16);
        run_one("b2b 9999", 16'd9999, 20'h09999, exp_blank(5'b10000), 1'b1);
        @(negedge clk);

        // Reset mid-conversion aborts; done must never pulse.
        kick(16'd4321);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort bcd", 32'(bcd_out), 32'h0);
        check("abort busy", 32'(busy), 32'd0);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen |= done;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            seen |= done;
        end
        check("abort no done", 32'(seen), 32'd0);
        check("abort bcd held", 32'(bcd_out), 32'h0);
        run_one("after abort 7", 16'd7, 20'h00007, exp_blank(5'b11110), 1'b1);

        // Back-to-back sparse sweep against the decimal reference.
        for (int v = 0; v <= 65535; v += 1021) begin
            run_one($sformatf("sweep %0d", v), 16'(v), ref_bcd(v), 5'b0, 1'b0);
        end
        run_one("sweep 65535", 16'hffff, ref_bcd(65535), 5'b0, 1'b0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
